// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for one 16-bit shifter.
// Operands and result are registered; results return on per-requester channels.
module shift_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_data,
    input  logic [3:0]  req0_amt,
    input  logic [1:0]  req0_mode,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_data,
    input  logic [3:0]  req1_amt,
    input  logic [1:0]  req1_mode,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RESP
    } state_t;

    state_t      state;
    logic [15:0] data_q;
    logic [3:0]  amt_q;
    logic [1:0]  mode_q;
    logic [15:0] result_q;
    logic        last_grant;
    logic        win;
    logic        idle;
    logic        take;
    logic        rsp_take;
    logic [15:0] shifted;
    logic [31:0] rot;

    assign idle = (state == IDLE);

    // Contention goes to whoever did not own the previous operation.
    always_comb begin
        win = req1_valid;
        if (req0_valid && req1_valid)
            win = ~last_grant;
    end

    assign req0_ready = idle && req0_valid && !win;
    assign req1_ready = idle && req1_valid && win;
    assign take       = req0_ready || req1_ready;
    assign rsp_take   = grant_id ? rsp1_ready : rsp0_ready;

    assign rot = {data_q, data_q} >> amt_q;

    always_comb begin
        shifted = data_q;
        unique case (mode_q)
            2'b00: shifted = data_q << amt_q;
            2'b01: shifted = $unsigned($signed(data_q) >>> amt_q);
            2'b10: shifted = rot[15:0];
            2'b11: shifted = data_q;
        endcase
    end

    assign busy       = !idle;
    assign rsp0_valid = (state == RESP) && !grant_id;
    assign rsp1_valid = (state == RESP) && grant_id;
    assign rsp_data   = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            data_q     <= '0;
            amt_q      <= '0;
            mode_q     <= '0;
            result_q   <= '0;
            grant_id   <= RR_INIT;
            last_grant <= ~RR_INIT;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        data_q   <= win ? req1_data : req0_data;
                        amt_q    <= win ? req1_amt  : req0_amt;
                        mode_q   <= win ? req1_mode : req0_mode;
                        grant_id <= win;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    result_q <= shifted;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        last_grant <= grant_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
